err_rsp_fw_reader: RTL and testbench
====================================

// Module: err_rsp_fw_reader
// PURPOSE
//  - FW-facing read side of the error-response FIFO. It is the consumer of the basic_fifo that the CRC engine fills.
//  - Prefetches the head entry into a holding register, popping the FIFO once per entry.
//  - Exposes the entry to FW as BUS_WIDTH-bit register words, plus a STATUS word.
//  - Releases the holding register when FW reads the last data word. Raises a level IRQ while an entry is held.
// PARAMETERS
//  RSP_WIDTH  72  width of one error-response entry (crc_param_rsp_t)
//  BUS_WIDTH  32  FW read data width
//  NUM_WORDS  ceil(RSP_WIDTH/BUS_WIDTH)  localparam, data words per entry (3 at defaults)
//  ADDR_WIDTH 4   word-address width; must satisfy 2**ADDR_WIDTH > NUM_WORDS
// PORTS
//  i_clk           in   1           clock; single clock domain
//  i_reset         in   1           synchronous, active-high reset
//  i_fifo_empty    in   1           FIFO empty; i_fifo_rd_data is valid when 0 (show-ahead)
//  i_fifo_rd_data  in   RSP_WIDTH   FIFO head entry
//  o_fifo_pop      out  1           one-cycle pop pulse to FIFO
//  i_fw_rd_req     in   1           FW read request, one per cycle max, pipelined
//  i_fw_rd_addr    in   ADDR_WIDTH  word address: 0=STATUS, 1..NUM_WORDS=data word (addr-1)
//  o_fw_rd_ack     out  1           read response valid, exactly 1 cycle after i_fw_rd_req
//  o_fw_rd_data    out  BUS_WIDTH   read response data
//  o_irq           out  1           level, =1 while holding register valid
// BEHAVIOUR
//  - Reset values: o_fifo_pop=0, o_fw_rd_ack=0, o_fw_rd_data=0, o_irq=0, hold_vld=0, hold_data=0, FSM=IDLE.
//  - FSM has two states, IDLE and HOLD.
//    - IDLE & !i_fifo_empty: capture i_fifo_rd_data into hold_data, pulse o_fifo_pop in the same cycle, then go to HOLD.
//    - IDLE & i_fifo_empty: stay in IDLE, no pop.
//    - HOLD: hold_vld=1, o_irq=1, no pops. Leave HOLD (->IDLE) in the cycle the last-word read is accepted.
//    - Earliest reload is the cycle after release, so there is a minimum 1-cycle IDLE gap between entries.
//  - Read pipeline. A request accepted in cycle N gives o_fw_rd_ack=1 in N+1 with the registered data.
//    - o_fw_rd_data=0 whenever ack=0.
//    - Data reflects hold_data as it was at cycle N.
//  - STATUS word (addr 0)
//    - [0]  hold_vld
//    - [1]  i_fifo_empty
//    - [15:2] 0
//    - [31:16] consumed count (see CONFIGURATION), otherwise 0.
//  - Data word k (addr k+1) returns hold_data[k*BUS_WIDTH +: BUS_WIDTH].
//    - The top word is zero-extended above RSP_WIDTH.
//  - Release condition: accepted read of addr NUM_WORDS while hold_vld=1.
//    - Other words may be read any number of times, in any order, with no side effect.
//  - Data read while hold_vld=0 returns 0 and has no side effect.
//  - Addr > NUM_WORDS returns 0 and has no side effect.
//  - Last-word read in the same cycle the FIFO becomes non-empty: release first, reload in the next cycle, pop in that cycle.
//  - o_fifo_pop is never asserted while i_fifo_empty=1. At most one pop per entry.
//  - Reset mid-HOLD clears the holding register. The already-popped entry is discarded; FW sees hold_vld=0.
//  - Reset during a pending ack: ack is dropped.
// CONFIGURATION
//  - ERR_RSP_RD_CNT_EN defined:
//    - 16-bit consumed counter, incremented on each release, saturating at 16'hFFFF.
//    - Reset to 0. Visible in STATUS[31:16].
//  - ERR_RSP_RD_CNT_EN undefined:
//    - No counter logic; STATUS[31:16]=0.
// STRUCTURE
//  - crc_pkg holds: CRC_PARAM_RSP_WITDH, crc_param_rsp_t, CRC_REQ_MAX_OUTSTAND.
//  - Also in crc_pkg: localparams ERR_RSP_STATUS_ADDR=0, ERR_RSP_DATA_ADDR_BASE=1, and the FSM state enum err_rsp_rd_state_e.
//  - Single module, no sub-modules. Word select is a generate/indexed part-select.
//  - Top level instantiates this module next to the err_rsp FIFO wrapper: o_fifo_pop -> i_fifo_pop, FIFO status and data -> inputs.
// TESTING
//  1. Reset, FIFO empty, read addr 0.
//     -> ack next cycle, data=32'h0000_0002, o_irq=0, no pop.
//  2. FIFO shows 72'hAB_1234_5678_9ABC_DEF0 with empty=0.
//     -> one pop pulse, o_irq=1 next cycle.
//     -> reads addr 1,2,3 return 9ABC_DEF0, 1234_5678, 0000_00AB.
//  3. Read addr 1 repeatedly (5x) while held.
//     -> same data each time, no pop, o_irq stays 1.
//     -> then read addr 3 releases, o_irq=0 next cycle.
//  4. Three entries in FIFO, FW reads all words of each.
//     -> exactly 3 pops, each pop the cycle after the previous release.
//     -> with ERR_RSP_RD_CNT_EN, STATUS[31:16]=3.
//  5. Read addr 2 and addr 7 with hold_vld=0.
//     -> data 0, no pop, FSM stays IDLE.
//  6. Assert i_reset while in HOLD with a read in flight.
//     -> next cycle: ack=0, o_irq=0, STATUS[0]=0; the FIFO entry is not re-popped.

Source files
------------

// File: rtl/crc_pkg.sv
// Shared CRC-engine types and constants, including the error-response FW reader's
// register map and FSM state encoding.
package crc_pkg;

    localparam int unsigned CRC_PARAM_RSP_WITDH  = 72;
    localparam int unsigned CRC_REQ_MAX_OUTSTAND = 4;

    typedef logic [CRC_PARAM_RSP_WITDH-1:0] crc_param_rsp_t;

    localparam int unsigned ERR_RSP_STATUS_ADDR    = 0;
    localparam int unsigned ERR_RSP_DATA_ADDR_BASE = 1;

    typedef enum logic [0:0] {
        ERR_RSP_RD_IDLE = 1'b0,
        ERR_RSP_RD_HOLD = 1'b1
    } err_rsp_rd_state_e;

endpackage

// File: rtl/err_rsp_fw_reader.sv
// FW read side of the error-response FIFO: prefetches one entry, serves it as register words.
// Optional consumed-entry counter in STATUS[31:16] is enabled by defining ERR_RSP_RD_CNT_EN.
module err_rsp_fw_reader
    import crc_pkg::*;
#(
    parameter int unsigned RSP_WIDTH  = CRC_PARAM_RSP_WITDH,
    parameter int unsigned BUS_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_fifo_empty,
    input  logic [RSP_WIDTH-1:0]  i_fifo_rd_data,
    output logic                  o_fifo_pop,
    input  logic                  i_fw_rd_req,
    input  logic [ADDR_WIDTH-1:0] i_fw_rd_addr,
    output logic                  o_fw_rd_ack,
    output logic [BUS_WIDTH-1:0]  o_fw_rd_data,
    output logic                  o_irq
);

    localparam int unsigned NUM_WORDS = (RSP_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
    localparam int unsigned EXT_WIDTH = NUM_WORDS * BUS_WIDTH;
    localparam int unsigned LAST_ADDR = ERR_RSP_DATA_ADDR_BASE + NUM_WORDS - 1;

    err_rsp_rd_state_e     state;
    logic [RSP_WIDTH-1:0]  hold_data;
    logic                  hold_vld;
    logic                  load;
    logic                  release_hit;
    logic [EXT_WIDTH-1:0]  hold_ext;
    logic [BUS_WIDTH-1:0]  status_word;
    logic [BUS_WIDTH-1:0]  read_word;
    logic [NUM_WORDS-1:0]  word_hit;
    logic [BUS_WIDTH-1:0]  word_acc [NUM_WORDS+1];

    assign hold_vld    = (state == ERR_RSP_RD_HOLD);
    assign o_irq       = hold_vld;
    // Pop is the same-cycle handshake of the show-ahead FIFO; the entry is captured on this edge.
    assign load        = !i_reset && (state == ERR_RSP_RD_IDLE) && !i_fifo_empty;
    assign o_fifo_pop  = load;
    assign release_hit = hold_vld && i_fw_rd_req && (i_fw_rd_addr == ADDR_WIDTH'(LAST_ADDR));
    assign hold_ext    = EXT_WIDTH'(hold_data);

`ifdef ERR_RSP_RD_CNT_EN
    logic [15:0] rd_cnt;

    // Consumed-entry counter, saturating.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_cnt <= '0;
        end else if (release_hit && (rd_cnt != 16'hFFFF)) begin
            rd_cnt <= rd_cnt + 16'd1;
        end
    end
`endif

    always_comb begin
        status_word    = '0;
        status_word[0] = hold_vld;
        status_word[1] = i_fifo_empty;
`ifdef ERR_RSP_RD_CNT_EN
        status_word[31:16] = rd_cnt;
`endif
    end

    // Data words only answer while an entry is held; the top word is zero-extended.
    assign word_acc[0] = '0;
    for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
        assign word_hit[k]   = hold_vld &&
                               (i_fw_rd_addr == ADDR_WIDTH'(ERR_RSP_DATA_ADDR_BASE + k));
        assign word_acc[k+1] = word_acc[k] |
                               (word_hit[k] ? hold_ext[k*BUS_WIDTH +: BUS_WIDTH] : '0);
    end

    always_comb begin
        read_word = word_acc[NUM_WORDS];
        if (i_fw_rd_addr == ADDR_WIDTH'(ERR_RSP_STATUS_ADDR)) begin
            read_word = status_word;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= ERR_RSP_RD_IDLE;
            hold_data    <= '0;
            o_fw_rd_ack  <= 1'b0;
            o_fw_rd_data <= '0;
        end else begin
            o_fw_rd_ack  <= i_fw_rd_req;
            o_fw_rd_data <= i_fw_rd_req ? read_word : '0;
            case (state)
                ERR_RSP_RD_IDLE: begin
                    if (load) begin
                        hold_data <= i_fifo_rd_data;
                        state     <= ERR_RSP_RD_HOLD;
                    end
                end
                ERR_RSP_RD_HOLD: begin
                    if (release_hit) begin
                        state <= ERR_RSP_RD_IDLE;
                    end
                end
                default: state <= ERR_RSP_RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_err_rsp_fw_reader.sv
// Self-checking bench for err_rsp_fw_reader: FIFO + FW-view model, directed and random traffic.
module tb_err_rsp_fw_reader;

    localparam int NW = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_empty;
    logic [71:0] fifo_rd_data;
    logic        fifo_pop;
    logic        rd_req;
    logic [3:0]  rd_addr;
    logic        rd_ack;
    logic [31:0] rd_data;
    logic        irq;

    err_rsp_fw_reader dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_fifo_empty   (fifo_empty),
        .i_fifo_rd_data (fifo_rd_data),
        .o_fifo_pop     (fifo_pop),
        .i_fw_rd_req    (rd_req),
        .i_fw_rd_addr   (rd_addr),
        .o_fw_rd_ack    (rd_ack),
        .o_fw_rd_data   (rd_data),
        .o_irq          (irq)
    );

    always #5 clk = ~clk;

    logic [71:0] q[$];
    logic        m_hold;
    logic [71:0] m_data;
    logic [15:0] m_cnt;
    logic        e_ack;
    logic [31:0] e_data;
    logic        last_pop;
    int          npop;
    int          nchk;
    int          nerr;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fw_word(input logic [3:0] addr, input logic empty);
        logic [95:0] ext;
        logic [15:0] cnt;
        ext = 96'(m_data);
`ifdef ERR_RSP_RD_CNT_EN
        cnt = m_cnt;
`else
        cnt = 16'h0;
`endif
        if (addr == 4'd0)
            return {cnt, 14'h0, empty, m_hold};
        if (m_hold && addr >= 4'd1 && addr <= 4'(NW))
            return ext[(int'(addr) - 1) * 32 +: 32];
        return 32'h0;
    endfunction

    // One clock: drive inputs, check pop, advance model, check registered outputs.
    task automatic step(input logic r, input logic req, input logic [3:0] addr,
                        input logic push, input logic [71:0] pdata);
        logic exp_pop;
        rst          = r;
        rd_req       = req;
        rd_addr      = addr;
        fifo_empty   = (q.size() == 0);
        fifo_rd_data = (q.size() != 0) ? q[0] : 72'({$urandom, $urandom, $urandom});
        #1;
        exp_pop  = !r && !m_hold && (q.size() != 0);
        last_pop = fifo_pop;
        chk("pop", fifo_pop, exp_pop);
        if (r) begin
            m_hold = 1'b0;
            m_data = '0;
            m_cnt  = '0;
            e_ack  = 1'b0;
            e_data = '0;
        end else begin
            e_ack  = req;
            e_data = req ? fw_word(addr, fifo_empty) : 32'h0;
            if (exp_pop) begin
                m_hold = 1'b1;
                m_data = q[0];
            end else if (m_hold && req && addr == 4'(NW)) begin
                m_hold = 1'b0;
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
        end
        @(posedge clk);
        if (last_pop) begin
            npop++;
            if (q.size() != 0) void'(q.pop_front());
        end
        if (push) q.push_back(pdata);
        @(negedge clk);
        chk("ack", rd_ack, e_ack);
        chk("data", rd_data, e_data);
        chk("irq", irq, m_hold);
    endtask

    initial begin
        logic [71:0] ent [3];
        logic [15:0] cnt_exp;
        nchk = 0; nerr = 0; npop = 0;
        m_hold = 0; m_data = 0; m_cnt = 0;
        rst = 1; rd_req = 0; rd_addr = 0; fifo_empty = 1; fifo_rd_data = 0;
        @(negedge clk);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("t0_reset_ack", rd_ack, 1'b0);
        chk("t0_reset_irq", irq, 1'b0);

        // 1: status read on empty FIFO
        step(0, 1, 0, 0, 0);
        chk("t1_status", rd_data, 32'h0000_0002);
        chk("t1_ack", rd_ack, 1'b1);
        chk("t1_pop", last_pop, 1'b0);

        // 2: single entry
        step(0, 0, 0, 1, 72'hAB_1234_5678_9ABC_DEF0);
        step(0, 0, 0, 0, 0);
        chk("t2_pop", last_pop, 1'b1);
        chk("t2_irq", irq, 1'b1);
        step(0, 1, 1, 0, 0);
        chk("t2_w0", rd_data, 32'h9ABC_DEF0);
        step(0, 1, 2, 0, 0);
        chk("t2_w1", rd_data, 32'h1234_5678);

        // 3: repeated reads are side-effect free, last word releases
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1, 0, 0);
            chk("t3_rep", rd_data, 32'h9ABC_DEF0);
            chk("t3_irq", irq, 1'b1);
        end
        step(0, 1, 3, 0, 0);
        chk("t3_w2", rd_data, 32'h0000_00AB);
        chk("t3_irq_off", irq, 1'b0);

        // 4: three entries back to back
        step(1, 0, 0, 0, 0);
        npop = 0;
        for (int e = 0; e < 3; e++) begin
            ent[e] = 72'({$urandom, $urandom, $urandom});
            step(0, 0, 0, 1, ent[e]);
        end
        for (int e = 0; e < 3; e++) begin
            step(0, 0, 0, 0, 0);
            for (int w = 1; w <= NW; w++) step(0, 1, 4'(w), 0, 0);
        end
        step(0, 0, 0, 0, 0);
        chk("t4_pops", npop, 3);
`ifdef ERR_RSP_RD_CNT_EN
        cnt_exp = 16'd3;
`else
        cnt_exp = 16'd0;
`endif
        step(0, 1, 0, 0, 0);
        chk("t4_status", rd_data, {cnt_exp, 16'h0002});

        // 5: data reads while idle
        step(0, 1, 2, 0, 0);
        chk("t5_a2", rd_data, 32'h0);
        chk("t5_pop", last_pop, 1'b0);
        step(0, 1, 7, 0, 0);
        chk("t5_a7", rd_data, 32'h0);
        chk("t5_irq", irq, 1'b0);

        // 6: reset mid-HOLD with a read in flight
        step(0, 0, 0, 1, 72'h11_2233_4455_6677_8899);
        step(0, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        chk("t6_held", irq, 1'b1);
        step(1, 1, 1, 0, 0);
        chk("t6_ack", rd_ack, 1'b0);
        chk("t6_irq", irq, 1'b0);
        npop = 0;
        step(0, 1, 0, 0, 0);
        chk("t6_status", rd_data, 32'h0000_0002);
        step(0, 0, 0, 0, 0);
        chk("t6_no_repop", npop, 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic r, rq, ps;
            r  = ($urandom_range(0, 299) == 0);
            rq = ($urandom_range(0, 9) < 6);
            ps = ($urandom_range(0, 5) == 0) && (q.size() < 4);
            step(r, rq, 4'($urandom_range(0, 9)), ps, 72'({$urandom, $urandom, $urandom}));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
